kmap_lut_engine: RTL and testbench
==================================

Name: kmap_lut_engine

Overview:
- Programmable, parametrised truth-table evaluator: replaces hard-coded per-function K-map blocks with one registered lookup engine that has an explicit don't-care policy.
- Holds a double-buffered table of 2^N_IN entries, each {care, value}: shadow bank written through a config port, active bank used for lookups.
- Lookups use valid/ready handshake with 1-cycle registered latency; sits between stimulus decode and checker/compare logic.

Parameters:
- N_IN, 4, number of function inputs; table depth 2^N_IN; legal range 2..8
- DC_FILL, 0, value driven on out when the addressed entry has care=0 (0 or 1)
- GEN_W, 8, width of the commit generation counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer when cfg_valid&&cfg_ready
- cfg_op  in  2  0=WRITE, 1=CLEAR, 2=COMMIT, 3=NOP (accepted, no effect)
- cfg_addr  in  N_IN  minterm index for WRITE, {a,b,c,...} MSB-first
- cfg_value  in  1  entry value for WRITE
- cfg_care  in  1  entry care bit for WRITE; 0 marks don't-care
- in_valid  in  1  lookup request
- in_ready  out  1  lookup accept
- in_vec  in  N_IN  minterm index to evaluate
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out  out  1  function result
- out_dc  out  1  1 when the result came from a don't-care entry
- busy  out  1  high while CLEAR sweep runs
- table_gen  out  GEN_W  count of completed commits, wraps at 2^GEN_W

Behaviour:
- Reset, async:
  - out_valid=0, out=0, out_dc=0, busy=0, table_gen=0, FSM=IDLE.
  - Both banks are all {care=0, value=0}, so any lookup before the first commit returns out=DC_FILL, out_dc=1.
- FSM states:
  - IDLE: cfg_ready=1.
    - WRITE: shadow[cfg_addr] <= {cfg_care, cfg_value} next edge.
    - COMMIT: active <= shadow (whole bank, one edge); table_gen += 1, wrapping.
    - CLEAR: go to SWEEP, counter=0.
  - SWEEP: cfg_ready=0, busy=1. Each cycle writes shadow[counter] <= {0,0} and increments counter. After index 2^N_IN-1, return to IDLE. Duration is exactly 2^N_IN cycles after the accept edge.
- SWEEP touches only shadow. Lookups keep running against active with no stall.
- Lookup path:
  - in_ready = !out_valid || out_ready.
  - On accept, the next edge registers out_valid=1, out_dc=!active[in_vec].care, out = care ? value : DC_FILL.
  - out_valid clears when out_ready=1 and no new accept occurs in that cycle.
  - Back-to-back lookups give 1 result per cycle when out_ready is held high.
  - While out_valid&&!out_ready, out and out_dc stay stable.
- Simultaneous events:
  - Lookup accepted in the same cycle as a COMMIT accept uses the pre-commit active bank.
  - WRITE and lookup in the same cycle are independent: shadow vs active.
  - COMMIT issued after a WRITE in the prior cycle includes that write.
- Reset asserted mid-SWEEP or mid-handshake: all state returns to reset values immediately; a partial sweep is discarded.
- Width rules: cfg_addr and in_vec are full-range, so no out-of-range case exists. table_gen wraps silently from 2^GEN_W-1 to 0.

Decomposition:
- Shared package kmap_pkg:
  - cfg_op enum (OP_WRITE, OP_CLEAR, OP_COMMIT, OP_NOP).
  - Entry struct {care, value}.
  - FSM state enum (IDLE, SWEEP).
- Sub-module kmap_lut_bank: holds one 2^N_IN x 2-bit bank with a single write port, a bulk-load port and a combinational read port. Instantiated twice, shadow and active.

Test Plan:
- Reset then lookup in_vec=4'h5, N_IN=4, DC_FILL=0 -> out=0, out_dc=1, out_valid 1 cycle after accept; table_gen=0.
- Program one entry per minterm:
  - WRITE care=1 for 0,1,5,6,7 (value 0) and 2,3,8,a,b,c,e,f (value 1).
  - WRITE care=0 for 4,9,d.
  - Then COMMIT.
  - Expect table_gen=1. Sweep in_vec 0..f -> out matches the programmed values, out_dc=1 only at 4,9,d.
- Same table with DC_FILL=1 -> minterms 4,9,d give out=1, out_dc=1; all others unchanged.
- Issue CLEAR, then lookups during busy -> busy=1 and cfg_ready=0 for exactly 16 cycles; lookups still return the committed table. A COMMIT afterwards gives every lookup out_dc=1.
- Hold out_ready=0 with in_valid=1 -> in_ready=0 after the first accept and out stays stable. Release -> one result per cycle, no loss or duplication.
- COMMIT and lookup accepted in the same cycle -> the lookup returns the old-table value. Also assert reset mid-SWEEP -> busy=0, table_gen=0, out_valid=0 asynchronously.

Source files
------------

// File: rtl/kmap_pkg.sv
// -----------------------------------------------------------------------------
// kmap_pkg
// Shared types for the programmable truth-table lookup engine.
//   cfg_op_e : configuration opcodes carried on cfg_op
//   entry_t  : one table entry, {care, value}; care=0 marks a don't-care
//   state_e  : configuration FSM states
// -----------------------------------------------------------------------------
package kmap_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_COMMIT = 2'd2,
        OP_NOP    = 2'd3
    } cfg_op_e;

    typedef struct packed {
        logic care;
        logic value;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam entry_t ENTRY_EMPTY = '{care: 1'b0, value: 1'b0};

endpackage

// File: rtl/kmap_lut_bank.sv
// -----------------------------------------------------------------------------
// kmap_lut_bank
// One 2^N_IN x {care, value} table bank built from flops.
//   clk, reset   : clock, asynchronous active-high reset (bank clears to empty)
//   wr_*         : single-entry write port
//   load_*       : bulk load of the whole bank in one edge (wins over wr_*)
//   rd_addr_i    : combinational read address, rd_data_o the addressed entry
//   bank_o       : full bank contents, feeds the bulk-load port of another bank
// -----------------------------------------------------------------------------
module kmap_lut_bank
    import kmap_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [N_IN-1:0]              wr_addr_i,
    input  entry_t                       wr_data_i,
    input  logic                         load_en_i,
    input  entry_t [(1 << N_IN)-1:0]     load_data_i,
    input  logic [N_IN-1:0]              rd_addr_i,
    output entry_t                       rd_data_o,
    output entry_t [(1 << N_IN)-1:0]     bank_o
);

    entry_t [(1 << N_IN)-1:0] mem_q;

    // NOTE: this table must read as all don't-care straight out of reset, so it
    // is a flop array with a reset, not an inferred RAM (RAMs cannot be reset).
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (load_en_i) begin
            mem_q <= load_data_i;
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
    assign bank_o    = mem_q;

endmodule

// File: rtl/kmap_lut_engine.sv
// -----------------------------------------------------------------------------
// kmap_lut_engine
// Registered truth-table evaluator with a double-buffered table. The shadow bank
// is edited through the config port; COMMIT copies it into the active bank that
// serves lookups, so edits never disturb lookups in flight.
//   clk, reset                  : clock, asynchronous active-high reset
//   cfg_valid/cfg_ready, cfg_op : config handshake; WRITE, CLEAR, COMMIT, NOP
//   cfg_addr/value/care         : entry written by WRITE
//   in_valid/in_ready, in_vec   : lookup request
//   out_valid/out_ready         : result handshake, 1-cycle registered latency
//   out, out_dc                 : result; out_dc=1 when the entry was don't-care
//   busy                        : CLEAR sweep in progress (config stalled)
//   table_gen                   : number of commits, wrapping
// -----------------------------------------------------------------------------
module kmap_lut_engine
    import kmap_pkg::*;
#(
    parameter int   N_IN    = 4,
    parameter logic DC_FILL = 1'b0,
    parameter int   GEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_op,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic             cfg_value,
    input  logic             cfg_care,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic             out_dc,
    output logic             busy,
    output logic [GEN_W-1:0] table_gen
);

    localparam int DEPTH = 1 << N_IN;

    cfg_op_e                op;
    state_e                 state_q, state_d;
    logic [N_IN-1:0]        cnt_q, cnt_d;
    logic [GEN_W-1:0]       gen_q, gen_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_q, out_d;
    logic                   out_dc_q, out_dc_d;

    logic                   sh_wr_en;
    logic [N_IN-1:0]        sh_wr_addr;
    entry_t                 sh_wr_data;
    logic                   act_load;
    entry_t [DEPTH-1:0]     shadow_bank;
    entry_t                 act_rd;
    logic                   in_fire;

    entry_t                 unused_sh_rd;
    entry_t [DEPTH-1:0]     unused_act_bank;

    assign op = cfg_op_e'(cfg_op);

    kmap_lut_bank #(.N_IN(N_IN)) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (sh_wr_en),
        .wr_addr_i   (sh_wr_addr),
        .wr_data_i   (sh_wr_data),
        .load_en_i   (1'b0),
        .load_data_i ('0),
        .rd_addr_i   ('0),
        .rd_data_o   (unused_sh_rd),
        .bank_o      (shadow_bank)
    );

    kmap_lut_bank #(.N_IN(N_IN)) u_active (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (1'b0),
        .wr_addr_i   ('0),
        .wr_data_i   (ENTRY_EMPTY),
        .load_en_i   (act_load),
        .load_data_i (shadow_bank),
        .rd_addr_i   (in_vec),
        .rd_data_o   (act_rd),
        .bank_o      (unused_act_bank)
    );

    // Configuration FSM: IDLE accepts ops, SWEEP clears the shadow one entry per
    // cycle. Only shadow is touched, so lookups continue against active.
    // NOTE: every signal written here gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gen_d      = gen_q;
        sh_wr_en   = 1'b0;
        sh_wr_addr = cfg_addr;
        sh_wr_data = '{care: cfg_care, value: cfg_value};
        act_load   = 1'b0;
        cfg_ready  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    case (op)
                        OP_WRITE:  sh_wr_en = 1'b1;
                        OP_COMMIT: begin
                            act_load = 1'b1;
                            gen_d    = gen_q + GEN_W'(1);
                        end
                        OP_CLEAR: begin
                            state_d = SWEEP;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            SWEEP: begin
                busy       = 1'b1;
                sh_wr_en   = 1'b1;
                sh_wr_addr = cnt_q;
                sh_wr_data = ENTRY_EMPTY;
                cnt_d      = cnt_q + N_IN'(1);
                // All-ones counter means the last entry is being cleared.
                if (&cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lookup pipeline: single output register; a new accept may replace the
    // result in the same cycle it is consumed. act_rd is pre-edge, so a lookup
    // accepted alongside a COMMIT sees the old table.
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_dc_d    = out_dc_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_dc_d    = !act_rd.care;
            out_d       = act_rd.care ? act_rd.value : DC_FILL;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gen_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            out_dc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gen_q       <= gen_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_dc_q    <= out_dc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_dc    = out_dc_q;
    assign table_gen = gen_q;

endmodule

// File: tb/tb_kmap_lut_engine.sv
// -----------------------------------------------------------------------------
// tb_kmap_lut_engine
// Two engines (DC_FILL=0 and DC_FILL=1) share every input. A reference model of
// the shadow/active tables predicts each lookup result into a queue; a separate
// monitor compares whatever the engines present against the queue head.
// -----------------------------------------------------------------------------
module tb_kmap_lut_engine;

    localparam int N_IN  = 4;
    localparam int DEPTH = 16;
    localparam int GEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic [1:0]       cfg_op;
    logic [N_IN-1:0]  cfg_addr;
    logic             cfg_value;
    logic             cfg_care;
    logic             in_valid;
    logic [N_IN-1:0]  in_vec;
    logic             out_ready;

    logic             cfg_ready0, in_ready0, out_valid0, out0, out_dc0, busy0;
    logic [GEN_W-1:0] gen0;
    logic             cfg_ready1, in_ready1, out_valid1, out1, out_dc1, busy1;
    logic [GEN_W-1:0] gen1;

    kmap_lut_engine #(.N_IN(N_IN), .DC_FILL(1'b0), .GEN_W(GEN_W)) dut0 (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready0), .cfg_op(cfg_op),
        .cfg_addr(cfg_addr), .cfg_value(cfg_value), .cfg_care(cfg_care),
        .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
        .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
        .out_dc(out_dc0), .busy(busy0), .table_gen(gen0)
    );

    kmap_lut_engine #(.N_IN(N_IN), .DC_FILL(1'b1), .GEN_W(GEN_W)) dut1 (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1), .cfg_op(cfg_op),
        .cfg_addr(cfg_addr), .cfg_value(cfg_value), .cfg_care(cfg_care),
        .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
        .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
        .out_dc(out_dc1), .busy(busy1), .table_gen(gen1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit sh_care [DEPTH];
    bit sh_val  [DEPTH];
    bit ac_care [DEPTH];
    bit ac_val  [DEPTH];
    int gen_m;
    bit mv;            // an unconsumed result is being presented
    int sweep_left;    // cycles of CLEAR sweep still to run

    typedef struct {
        bit o0;
        bit o1;
        bit dc;
    } exp_t;
    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            sh_care[i] = 0; sh_val[i] = 0; ac_care[i] = 0; ac_val[i] = 0;
        end
        gen_m = 0; mv = 0; sweep_left = 0;
    endtask

    task automatic set_cfg(input int op, input int addr, input bit val, input bit care);
        cfg_valid = 1'b1;
        cfg_op    = 2'(op);
        cfg_addr  = N_IN'(addr);
        cfg_value = val;
        cfg_care  = care;
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_op = 2'd3; cfg_addr = 0; cfg_value = 0; cfg_care = 0;
        in_valid = 0; in_vec = 0; out_ready = 1;
    endtask

    // Called at posedge+1 with inputs already set; checks the visible state at
    // posedge+4, advances the model across the coming edge, returns at posedge+1.
    task automatic tick();
        bit rdy_cfg, rdy_in, care;
        int a;
        #3;
        rdy_cfg = (sweep_left == 0);
        rdy_in  = !mv || out_ready;
        check("busy", busy0, !rdy_cfg);
        check("cfg_ready", cfg_ready0, rdy_cfg);
        check("in_ready", in_ready0, rdy_in);
        check("out_valid", out_valid0, mv);
        check("table_gen", gen0, gen_m);
        check("in_ready_fill1", in_ready1, rdy_in);
        check("out_valid_fill1", out_valid1, mv);
        if (sweep_left > 0) sweep_left--;
        if (in_valid && rdy_in) begin
            a = int'(in_vec);
            care = ac_care[a];
            sb.push_back('{o0: care ? ac_val[a] : 1'b0,
                           o1: care ? ac_val[a] : 1'b1,
                           dc: !care});
        end
        if (in_valid && rdy_in) mv = 1;
        else if (out_ready) mv = 0;
        if (cfg_valid && rdy_cfg) begin
            a = int'(cfg_addr);
            case (cfg_op)
                2'd0: begin sh_care[a] = cfg_care; sh_val[a] = cfg_value; end
                2'd1: begin
                    for (int i = 0; i < DEPTH; i++) begin sh_care[i] = 0; sh_val[i] = 0; end
                    sweep_left = DEPTH;
                end
                2'd2: begin
                    ac_care = sh_care; ac_val = sh_val;
                    gen_m = (gen_m + 1) % (1 << GEN_W);
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_all();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_vec = N_IN'(i); tick();
        end
        in_valid = 0;
        tick();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (!reset && out_valid0) begin
                if (sb.size() == 0) begin
                    check("result_expected", 0, 1);
                end else begin
                    e = sb[0];
                    check("out_fill0", out0, e.o0);
                    check("out_fill1", out1, e.o1);
                    check("out_dc_fill0", out_dc0, e.dc);
                    check("out_dc_fill1", out_dc1, e.dc);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] val_mask;
        logic [15:0] care_mask;
        int op;
        val_mask  = 16'hDD0C;   // value 1 at 2,3,8,a,b,c,e,f
        care_mask = 16'hDDEF;   // don't-care at 4,9,d

        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_out", out0, 0);
        check("rst_out_dc", out_dc0, 0);
        check("rst_busy", busy0, 0);
        check("rst_table_gen", gen0, 0);
        reset = 1'b0;

        // Lookup before any commit: don't-care everywhere.
        in_valid = 1; in_vec = 4'h5; tick();
        in_valid = 0; tick(); tick();

        // Program one entry per minterm with random lookups alongside, then commit.
        for (int i = 0; i < DEPTH; i++) begin
            set_cfg(0, i, val_mask[i], care_mask[i]);
            in_valid = 1'($urandom); in_vec = N_IN'($urandom);
            tick();
        end
        in_valid = 0;
        set_cfg(2, 0, 0, 0); tick();
        cfg_valid = 0;
        lookup_all();

        // CLEAR with lookups running; a WRITE held pending until the sweep ends.
        set_cfg(1, 0, 0, 0); tick();
        set_cfg(0, 3, 1, 1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1; in_vec = N_IN'($urandom); tick();
        end
        in_valid = 0;
        set_cfg(2, 0, 0, 0); tick();
        cfg_valid = 0;
        lookup_all();

        // Backpressure, then release.
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin in_vec = N_IN'($urandom); tick(); end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin in_vec = N_IN'($urandom); tick(); end
        in_valid = 0; tick();

        // COMMIT and lookup in the same cycle use the old table.
        set_cfg(0, 5, 1, 1); tick();
        set_cfg(2, 0, 0, 0); in_valid = 1; in_vec = 4'h5; tick();
        cfg_valid = 0; tick();
        in_valid = 0; tick();

        // Many commits: table_gen wraps.
        set_cfg(2, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'($urandom); in_vec = N_IN'($urandom); tick();
        end
        cfg_valid = 0;

        // Random mixed traffic.
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 3));
            if (op == 1 && $urandom_range(0, 7) != 0) op = 0;
            set_cfg(op, int'($urandom_range(0, DEPTH - 1)), 1'($urandom), 1'($urandom));
            cfg_valid = 1'($urandom);
            in_valid  = 1'($urandom);
            in_vec    = N_IN'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();
        repeat (DEPTH + 2) tick();
        check("sb_drained", sb.size(), 0);

        // Reset asserted mid-sweep with a result held.
        set_cfg(2, 0, 0, 0); tick();
        set_cfg(1, 0, 0, 0); tick();
        cfg_valid = 0; out_ready = 0; in_valid = 1; in_vec = N_IN'($urandom);
        tick(); tick(); tick();
        #1;
        reset = 1'b1;
        model_reset();
        sb.delete();
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_table_gen", gen0, 0);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_cfg_ready", cfg_ready0, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        tick();
        lookup_all();
        tick();
        check("sb_final_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
